// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite scheduler: pixel coordinates,
// colours, per-sprite configuration record and the config FSM states.
package sprite_pkg;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned RGB_W   = 12;

  typedef logic signed [COORD_W-1:0] coord_t;
  typedef logic [RGB_W-1:0]          rgb_t;

  typedef struct packed {
    logic   en;
    coord_t row;
    coord_t col;
  } sprite_cfg_t;

  localparam rgb_t DEF_KEY_RGB = 12'hF0F;
  localparam rgb_t DEF_BG_RGB  = 12'h000;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } cfg_state_t;

endpackage

// File: rtl/sprite_hit_detect.sv
// Per-sprite hit test: checks whether the pixel lies inside the sprite square
// and returns the sprite-local row/col offsets.
module sprite_hit_detect
  import sprite_pkg::*;
#(
  parameter int unsigned DIM_LOG2 = 4
) (
  input  sprite_cfg_t         i_cfg,
  input  coord_t              i_row,
  input  coord_t              i_col,
  output logic                o_hit_c,
  output logic [DIM_LOG2-1:0] o_lrow_c,
  output logic [DIM_LOG2-1:0] o_lcol_c
);

  localparam int unsigned DW = COORD_W + 1;

  logic signed [DW-1:0] w_dr;
  logic signed [DW-1:0] w_dc;

  // One extra bit so differences of any two 11-bit coordinates cannot wrap.
  assign w_dr = $signed({i_row[COORD_W-1], i_row}) - $signed({i_cfg.row[COORD_W-1], i_cfg.row});
  assign w_dc = $signed({i_col[COORD_W-1], i_col}) - $signed({i_cfg.col[COORD_W-1], i_cfg.col});

  assign o_hit_c  = i_cfg.en && (w_dr[DW-1:DIM_LOG2] == '0) && (w_dc[DW-1:DIM_LOG2] == '0);
  assign o_lrow_c = w_dr[DIM_LOG2-1:0];
  assign o_lcol_c = w_dc[DIM_LOG2-1:0];

endmodule

// File: rtl/sprite_scheduler.sv
// Shares one sprite ROM between N_SPR sprites: priority hit selection, ROM
// addressing, colour keying and frame-synchronous config commit.
module sprite_scheduler
  import sprite_pkg::*;
#(
  parameter int unsigned N_SPR    = 4,
  parameter int unsigned DIM_LOG2 = 4,
  parameter rgb_t        BG_RGB   = DEF_BG_RGB,
  parameter rgb_t        KEY_RGB  = DEF_KEY_RGB,
  localparam int unsigned ID_W    = $clog2(N_SPR),
  localparam int unsigned ADDR_W  = ID_W + 2 * DIM_LOG2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  coord_t            pix_row,
  input  coord_t            pix_col,
  output logic [ADDR_W-1:0] rom_addr,
  input  rgb_t              rom_data,
  output logic              out_valid,
  output rgb_t              out_rgb,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ID_W-1:0]   cfg_id,
  input  logic              cfg_en,
  input  coord_t            cfg_row,
  input  coord_t            cfg_col,
  output logic              commit_pending
);

  sprite_cfg_t         r_shadow [N_SPR];
  sprite_cfg_t         r_active [N_SPR];
  cfg_state_t          r_state;
  cfg_state_t          w_state_nxt;
  logic                w_cfg_acc;
  logic                w_commit;
  logic [N_SPR-1:0]    w_hit;
  logic [DIM_LOG2-1:0] w_lrow [N_SPR];
  logic [DIM_LOG2-1:0] w_lcol [N_SPR];
  logic                w_any_hit;
  logic [ID_W-1:0]     w_win_id;
  logic [DIM_LOG2-1:0] w_win_row;
  logic [DIM_LOG2-1:0] w_win_col;
  logic                r_hit1;
  logic                r_valid1;

  for (genvar g = 0; g < N_SPR; g++) begin : g_hit
    sprite_hit_detect #(.DIM_LOG2(DIM_LOG2)) u_hit (
      .i_cfg    (r_active[g]),
      .i_row    (pix_row),
      .i_col    (pix_col),
      .o_hit_c  (w_hit[g]),
      .o_lrow_c (w_lrow[g]),
      .o_lcol_c (w_lcol[g])
    );
  end

  // Lowest index wins; only the winner is looked up.
  always_comb begin
    w_any_hit = 1'b0;
    w_win_id  = '0;
    w_win_row = '0;
    w_win_col = '0;
    for (int i = 0; i < N_SPR; i++) begin
      if (w_hit[i] && !w_any_hit) begin
        w_any_hit = 1'b1;
        w_win_id  = ID_W'(i);
        w_win_row = w_lrow[i];
        w_win_col = w_lcol[i];
      end
    end
  end

  // Writes are refused in the commit cycle so they never race the copy.
  assign cfg_ready = !frame_start;
  assign w_cfg_acc = cfg_valid && !frame_start;
  assign w_commit  = (r_state == S_PEND) && frame_start;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    commit_pending = 1'b0;
    case (r_state)
      S_IDLE: if (w_cfg_acc) w_state_nxt = S_PEND;
      S_PEND: begin
        commit_pending = 1'b1;
        if (w_commit) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_SPR; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      if (w_cfg_acc) r_shadow[cfg_id] <= '{en: cfg_en, row: cfg_row, col: cfg_col};
      if (w_commit) begin
        for (int i = 0; i < N_SPR; i++) r_active[i] <= r_shadow[i];
      end
    end
  end

  // Two-stage pixel pipeline: address/hit, then colour select.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr  <= '0;
      r_hit1    <= 1'b0;
      r_valid1  <= 1'b0;
      out_valid <= 1'b0;
      out_rgb   <= '0;
    end else begin
      if (w_any_hit) rom_addr <= {w_win_id, w_win_row, w_win_col};
      r_hit1    <= w_any_hit;
      r_valid1  <= pix_valid;
      out_valid <= r_valid1;
      if (!r_valid1)                         out_rgb <= '0;
      else if (!r_hit1 || rom_data == KEY_RGB) out_rgb <= BG_RGB;
      else                                   out_rgb <= rom_data;
    end
  end

endmodule

// File: tb/tb_sprite_scheduler.sv
// Bench for sprite_scheduler: table of pixel vectors plus hand sequences for
// commit shadowing, write/commit collision and mid-stream reset.
module tb_sprite_scheduler;
  import sprite_pkg::*;

  localparam int unsigned ADDR_W = 10;
  localparam rgb_t BG  = 12'h0A5;
  localparam rgb_t KEY = 12'hF0F;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_start;
  logic              pix_valid;
  coord_t            pix_row;
  coord_t            pix_col;
  logic [ADDR_W-1:0] rom_addr;
  rgb_t              rom_data;
  logic              out_valid;
  rgb_t              out_rgb;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_id;
  logic              cfg_en;
  coord_t            cfg_row;
  coord_t            cfg_col;
  logic              commit_pending;

  rgb_t rom_mem [1 << ADDR_W];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  typedef struct {
    int          due;
    bit          chk_addr;
    logic [9:0]  addr;
    bit          chk_pix;
    logic        v;
    rgb_t        rgb;
    string       name;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    coord_t     row;
    coord_t     col;
    logic       v;
    logic [9:0] addr;
    logic       ev;
    rgb_t       rgb;
    string      name;
  } vec_t;
  vec_t vt [11];

  sprite_scheduler #(.N_SPR(4), .DIM_LOG2(4), .BG_RGB(BG), .KEY_RGB(KEY)) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_start    (frame_start),
    .pix_valid      (pix_valid),
    .pix_row        (pix_row),
    .pix_col        (pix_col),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .out_valid      (out_valid),
    .out_rgb        (out_rgb),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_id         (cfg_id),
    .cfg_en         (cfg_en),
    .cfg_row        (cfg_row),
    .cfg_col        (cfg_col),
    .commit_pending (commit_pending)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  assign rom_data = rom_mem[rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      chk({e.name, "_due"}, 32'(e.due), 32'(cyc));
      if (e.chk_addr) chk({e.name, "_addr"}, 32'(rom_addr), 32'(e.addr));
      if (e.chk_pix) begin
        chk({e.name, "_valid"}, 32'(out_valid), 32'(e.v));
        chk({e.name, "_rgb"}, 32'(out_rgb), 32'(e.rgb));
      end
    end
  end

  task automatic drive(input string name, input logic fs, input logic v, input coord_t r,
                       input coord_t c, input bit ca, input logic [9:0] a, input bit cp,
                       input logic ev, input rgb_t er);
    exp_t e;
    @(negedge clk);
    frame_start = fs;
    pix_valid   = v;
    pix_row     = r;
    pix_col     = c;
    if (ca) begin
      e = '{due: cyc + 1, chk_addr: 1'b1, addr: a, chk_pix: 1'b0, v: 1'b0, rgb: '0, name: name};
      sbq.push_back(e);
    end
    if (cp) begin
      e = '{due: cyc + 2, chk_addr: 1'b0, addr: '0, chk_pix: 1'b1, v: ev, rgb: er, name: name};
      sbq.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive("idle", 1'b0, 1'b0, -11'sd1000, -11'sd1000, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic frame();
    drive("frame", 1'b1, 1'b0, -11'sd1000, -11'sd1000, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic cfg_write(input logic [1:0] id, input logic en, input coord_t r, input coord_t c);
    @(negedge clk);
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    cfg_valid   = 1'b1;
    cfg_id      = id;
    cfg_en      = en;
    cfg_row     = r;
    cfg_col     = c;
    @(posedge clk);
    #1 cfg_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) rom_mem[i] = 12'(i) ^ 12'h800;
    rom_mem[0]      = 12'hF00;
    rom_mem[10'h23] = KEY;

    vt[0]  = '{11'sd52,  11'sd53,  1'b1, 10'h023, 1'b1, BG,      "ovl_key"};
    vt[1]  = '{11'sd46,  11'sd47,  1'b1, 10'h212, 1'b1, 12'hA12, "id2_only"};
    vt[2]  = '{11'sd60,  11'sd45,  1'b1, 10'h2F0, 1'b1, 12'hAF0, "id2_lastrow"};
    vt[3]  = '{11'sd61,  11'sd45,  1'b1, 10'h2F0, 1'b1, BG,      "id2_below"};
    vt[4]  = '{11'sd10,  11'sd10,  1'b1, 10'h1FF, 1'b1, 12'h9FF, "neg_corner"};
    vt[5]  = '{11'sd11,  11'sd0,   1'b1, 10'h1FF, 1'b1, BG,      "neg_past"};
    vt[6]  = '{-11'sd5,  -11'sd5,  1'b1, 10'h100, 1'b1, 12'h900, "neg_origin"};
    vt[7]  = '{11'sd52,  11'sd53,  1'b0, 10'h023, 1'b0, 12'h000, "blank"};
    vt[8]  = '{11'sd65,  11'sd65,  1'b1, 10'h0FF, 1'b1, 12'h8FF, "id0_corner"};
    vt[9]  = '{11'sd305, 11'sd305, 1'b1, 10'h0FF, 1'b1, BG,      "id3_disabled"};
    vt[10] = '{11'sd50,  11'sd66,  1'b1, 10'h0FF, 1'b1, BG,      "id0_right"};

    rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0;
    pix_row = -11'sd1000; pix_col = -11'sd1000;
    cfg_valid = 1'b0; cfg_id = '0; cfg_en = 1'b0; cfg_row = '0; cfg_col = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_rgb", 32'(out_rgb), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_pending", 32'(commit_pending), 0);
    chk("rst_cfg_ready", 32'(cfg_ready), 1);
    rst = 1'b0;

    // Single sprite hit
    cfg_write(2'd0, 1'b1, 11'sd100, 11'sd100);
    chk("single_pending", 32'(commit_pending), 1);
    frame();
    idle(1);
    chk("single_committed", 32'(commit_pending), 0);
    drive("single_off", 1'b0, 1'b1, 11'sd101, 11'sd103, 1'b1, 10'h013, 1'b1, 1'b1, 12'h813);
    drive("single_org", 1'b0, 1'b1, 11'sd100, 11'sd100, 1'b1, 10'h000, 1'b1, 1'b1, 12'hF00);
    idle(3);

    // Multi-sprite table
    cfg_write(2'd0, 1'b1, 11'sd50, 11'sd50);
    cfg_write(2'd1, 1'b1, -11'sd5, -11'sd5);
    cfg_write(2'd2, 1'b1, 11'sd45, 11'sd45);
    cfg_write(2'd3, 1'b0, 11'sd300, 11'sd300);
    frame();
    for (int i = 0; i < 11; i++)
      drive(vt[i].name, 1'b0, vt[i].v, vt[i].row, vt[i].col, 1'b1, vt[i].addr, 1'b1, vt[i].ev, vt[i].rgb);
    idle(3);

    // Shadowing: id1 moved mid-frame, visible only after the next frame_start
    cfg_write(2'd1, 1'b1, 11'sd200, 11'sd200);
    chk("shadow_pending", 32'(commit_pending), 1);
    drive("shadow_pre", 1'b0, 1'b1, 11'sd200, 11'sd200, 1'b0, '0, 1'b1, 1'b1, BG);
    drive("shadow_fs_pix", 1'b1, 1'b1, 11'sd200, 11'sd200, 1'b0, '0, 1'b1, 1'b1, BG);
    drive("shadow_post", 1'b0, 1'b1, 11'sd200, 11'sd200, 1'b1, 10'h100, 1'b1, 1'b1, 12'h900);
    chk("shadow_cleared", 32'(commit_pending), 0);
    idle(3);

    // Write collides with frame_start: refused, then accepted next cycle
    @(negedge clk);
    frame_start = 1'b1; pix_valid = 1'b0;
    cfg_valid = 1'b1; cfg_id = 2'd3; cfg_en = 1'b1; cfg_row = 11'sd300; cfg_col = 11'sd300;
    #1 chk("coll_ready_low", 32'(cfg_ready), 0);
    @(negedge clk);
    frame_start = 1'b0;
    chk("coll_not_taken", 32'(commit_pending), 0);
    #1 chk("coll_ready_high", 32'(cfg_ready), 1);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("coll_pending", 32'(commit_pending), 1);
    frame();
    drive("coll_id3", 1'b0, 1'b1, 11'sd305, 11'sd305, 1'b1, 10'h355, 1'b1, 1'b1, 12'hB55);
    idle(3);

    // Reset mid-stream with a pending write
    cfg_write(2'd0, 1'b1, 11'sd400, 11'sd400);
    drive("pre_rst_a", 1'b0, 1'b1, 11'sd46, 11'sd47, 1'b0, '0, 1'b0, 1'b0, '0);
    drive("pre_rst_b", 1'b0, 1'b1, 11'sd46, 11'sd47, 1'b0, '0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_out_valid", 32'(out_valid), 0);
    chk("mrst_out_rgb", 32'(out_rgb), 0);
    chk("mrst_rom_addr", 32'(rom_addr), 0);
    chk("mrst_pending", 32'(commit_pending), 0);
    rst = 1'b0;
    pix_valid = 1'b0;
    frame();
    idle(1);
    chk("mrst_no_commit", 32'(commit_pending), 0);
    drive("mrst_lost", 1'b0, 1'b1, 11'sd400, 11'sd400, 1'b1, 10'h000, 1'b1, 1'b1, BG);
    drive("mrst_cleared", 1'b0, 1'b1, 11'sd46, 11'sd47, 1'b1, 10'h000, 1'b1, 1'b1, BG);
    idle(4);
    chk("sb_drain", 32'(sbq.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
